// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch from a combinational RAM with a
// valid/ready output register, branch redirect and start/halt control.
`ifndef DefaultWordSize
`define DefaultWordSize 8
`endif
`ifndef DefaultAddrSize
`define DefaultAddrSize 4
`endif
module fetch_unit #(
  parameter int WORD_SIZE = `DefaultWordSize,
  parameter int ADDR_SIZE = `DefaultAddrSize
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 branch_taken,
  input  logic [ADDR_SIZE-1:0] branch_target,
  input  logic [WORD_SIZE-1:0] mem_value,
  output logic [ADDR_SIZE-1:0] mem_address,
  output logic                 mem_load,
  output logic [WORD_SIZE-1:0] instr,
  output logic [ADDR_SIZE-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [ADDR_SIZE-1:0] pc,
  output logic                 running
);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, state_nxt;
  logic capture;
  assign running = state == FETCH;
  assign mem_address = pc;
  assign mem_load = 1'b0;
  // the output register refills when empty or being drained this same edge
  assign capture = running && !halt && !branch_taken && (!instr_valid || instr_ready);
  always_comb
    state_nxt = halt ? IDLE : (branch_taken ? state : ((state == IDLE && start) ? FETCH : state));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= '0;
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      pc <= branch_target;
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr <= mem_value;
      instr_pc <= pc;
      instr_valid <= 1'b1;
      pc <= pc + ADDR_SIZE'(1);
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tasks plus a randomized run against a
// rule-level reference model of the fetch unit.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       branch_taken = 1'b0;
  logic [3:0] branch_target = '0;
  logic [7:0] mem_value;
  logic [3:0] mem_address;
  logic       mem_load;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [3:0] pc;
  logic       running;
  logic [7:0] ram [16];
  int checks = 0;
  int fails = 0;

  fetch_unit #(.WORD_SIZE(8), .ADDR_SIZE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_value(mem_value), .mem_address(mem_address), .mem_load(mem_load),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .running(running)
  );

  assign mem_value = ram[mem_address];
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i + 16);
  endtask

  task automatic do_reset;
    start = 0; halt = 0; branch_taken = 0; instr_ready = 0;
    reset = 1;
    #2;
    reset = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({running, pc, instr_valid, instr, instr_pc, mem_load} !== 19'd0) begin
      fails++;
      $display("FAIL reset_state: run=%0d pc=%0d v=%0d instr=%0d ipc=%0d load=%0d, want all 0",
               running, pc, instr_valid, instr, instr_pc, mem_load);
    end
    tick;
    reset = 0;
    tick;
    checks++;
    if ({running, mem_load, instr_valid} !== 3'b000) begin
      fails++;
      $display("FAIL reset_release_idle: run=%0d load=%0d v=%0d, want 0 0 0", running, mem_load, instr_valid);
    end
  endtask

  task automatic test_stream;
    do_reset;
    start = 1; instr_ready = 1;
    tick;
    start = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if ({instr_valid, instr, instr_pc, pc, running} !== {1'b1, 8'(16 + k), 4'(k), 4'(k + 1), 1'b1}) begin
        fails++;
        $display("FAIL stream_%0d: v=%0d instr=%0d ipc=%0d pc=%0d run=%0d, want 1 %0d %0d %0d 1",
                 k, instr_valid, instr, instr_pc, pc, running, 16 + k, k, k + 1);
      end
    end
    halt = 1;
    tick;
    halt = 0;
    checks++;
    if ({running, instr_valid, pc} !== {1'b0, 1'b0, 4'd3}) begin
      fails++;
      $display("FAIL stream_halt: run=%0d v=%0d pc=%0d, want 0 0 3", running, instr_valid, pc);
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    start = 1; instr_ready = 1;
    tick;
    start = 0;
    tick;
    instr_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if ({instr_valid, instr, instr_pc, pc} !== {1'b1, 8'd16, 4'd0, 4'd1}) begin
        fails++;
        $display("FAIL backpressure_hold_%0d: v=%0d instr=%0d ipc=%0d pc=%0d, want 1 16 0 1",
                 k, instr_valid, instr, instr_pc, pc);
      end
    end
    instr_ready = 1;
    tick;
    checks++;
    if ({instr_valid, instr, instr_pc, pc} !== {1'b1, 8'd17, 4'd1, 4'd2}) begin
      fails++;
      $display("FAIL backpressure_release: v=%0d instr=%0d ipc=%0d pc=%0d, want 1 17 1 2",
               instr_valid, instr, instr_pc, pc);
    end
    halt = 1;
    tick;
    halt = 0;
  endtask

  task automatic test_wrap;
    do_reset;
    start = 1; instr_ready = 1;
    tick;
    start = 0; branch_taken = 1; branch_target = 14;
    tick;
    branch_taken = 0;
    checks++;
    if ({instr_valid, pc, running} !== {1'b0, 4'd14, 1'b1}) begin
      fails++;
      $display("FAIL wrap_branch: v=%0d pc=%0d run=%0d, want 0 14 1", instr_valid, pc, running);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if ({instr_valid, instr_pc, instr, pc} !== {1'b1, 4'(14 + k), 8'(((14 + k) % 16) + 16), 4'(15 + k)}) begin
        fails++;
        $display("FAIL wrap_seq_%0d: v=%0d ipc=%0d instr=%0d pc=%0d, want 1 %0d %0d %0d",
                 k, instr_valid, instr_pc, instr, pc, (14 + k) % 16, ((14 + k) % 16) + 16, (15 + k) % 16);
      end
    end
    halt = 1;
    tick;
    halt = 0;
  endtask

  task automatic test_branch_drop;
    do_reset;
    start = 1; instr_ready = 1;
    tick;
    start = 0;
    tick;
    instr_ready = 0;
    tick;
    branch_taken = 1; branch_target = 9;
    tick;
    branch_taken = 0;
    checks++;
    if ({instr_valid, pc} !== {1'b0, 4'd9}) begin
      fails++;
      $display("FAIL branch_drop: v=%0d pc=%0d, want 0 9", instr_valid, pc);
    end
    tick;
    checks++;
    if ({instr_valid, instr, instr_pc, pc} !== {1'b1, 8'd25, 4'd9, 4'd10}) begin
      fails++;
      $display("FAIL branch_refetch: v=%0d instr=%0d ipc=%0d pc=%0d, want 1 25 9 10",
               instr_valid, instr, instr_pc, pc);
    end
    halt = 1;
    tick;
    halt = 0;
  endtask

  task automatic test_halt;
    do_reset;
    start = 1; instr_ready = 1;
    tick;
    start = 0;
    tick;
    instr_ready = 0; halt = 1;
    tick;
    halt = 0;
    checks++;
    if ({running, instr_valid, instr, instr_pc, pc} !== {1'b0, 1'b1, 8'd16, 4'd0, 4'd1}) begin
      fails++;
      $display("FAIL halt_hold: run=%0d v=%0d instr=%0d ipc=%0d pc=%0d, want 0 1 16 0 1",
               running, instr_valid, instr, instr_pc, pc);
    end
    tick;
    checks++;
    if ({running, instr_valid, instr} !== {1'b0, 1'b1, 8'd16}) begin
      fails++;
      $display("FAIL halt_idle_hold: run=%0d v=%0d instr=%0d, want 0 1 16", running, instr_valid, instr);
    end
    instr_ready = 1;
    tick;
    checks++;
    if ({running, instr_valid, pc} !== {1'b0, 1'b0, 4'd1}) begin
      fails++;
      $display("FAIL halt_consume: run=%0d v=%0d pc=%0d, want 0 0 1", running, instr_valid, pc);
    end
    tick;
    tick;
    checks++;
    if ({running, instr_valid, pc} !== {1'b0, 1'b0, 4'd1}) begin
      fails++;
      $display("FAIL halt_no_fetch: run=%0d v=%0d pc=%0d, want 0 0 1", running, instr_valid, pc);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    start = 1; instr_ready = 1;
    tick;
    start = 0;
    tick;
    tick;
    #2;
    reset = 1;
    #1;
    checks++;
    if ({pc, instr_valid, running, mem_load} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: pc=%0d v=%0d run=%0d load=%0d, want 0 0 0 0", pc, instr_valid, running, mem_load);
    end
    reset = 0;
    tick;
    tick;
    checks++;
    if ({pc, instr_valid, running} !== {4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset_waits: pc=%0d v=%0d run=%0d, want 0 0 0", pc, instr_valid, running);
    end
  endtask

  task automatic test_random;
    bit m_run, m_valid;
    logic [3:0] m_pc, m_ipc;
    logic [7:0] m_instr;
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    do_reset;
    m_run = 0; m_valid = 0; m_pc = 0; m_ipc = 0; m_instr = 0;
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(3) == 0);
      halt = ($urandom_range(15) == 0);
      branch_taken = ($urandom_range(9) == 0);
      branch_target = 4'($urandom);
      instr_ready = ($urandom_range(2) != 0);
      if (branch_taken) begin
        m_pc = branch_target;
        m_valid = 0;
      end else if (m_run && !halt && (!m_valid || instr_ready)) begin
        m_instr = ram[m_pc];
        m_ipc = m_pc;
        m_valid = 1;
        m_pc = m_pc + 4'd1;
      end else if (m_valid && instr_ready) begin
        m_valid = 0;
      end
      if (halt) m_run = 0;
      else if (!branch_taken && start) m_run = 1;
      tick;
      checks++;
      if ({running, pc, mem_address, instr_valid, mem_load} !== {m_run, m_pc, m_pc, m_valid, 1'b0} ||
          (m_valid && {instr, instr_pc} !== {m_instr, m_ipc})) begin
        fails++;
        $display("FAIL random_%0d: run=%0d pc=%0d addr=%0d v=%0d instr=%0d ipc=%0d load=%0d, want run=%0d pc=%0d v=%0d instr=%0d ipc=%0d",
                 n, running, pc, mem_address, instr_valid, instr, instr_pc, mem_load,
                 m_run, m_pc, m_valid, m_instr, m_ipc);
      end
    end
  endtask

  initial begin
    preload;
    test_reset;
    test_stream;
    test_backpressure;
    test_wrap;
    test_branch_drop;
    test_halt;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default `DefaultWordSize, the instruction/data word width.
REQ-002 SHALL have parameter ADDR_SIZE, default `DefaultAddrSize, the RAM address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begins fetching from the current pc while in IDLE.
REQ-006 SHALL have port halt, input, 1, stops fetching and returns to IDLE.
REQ-007 SHALL have port branch_taken, input, 1, redirect request.
REQ-008 SHALL have port branch_target, input, ADDR_SIZE, redirect address.
REQ-009 SHALL have port mem_value, input, WORD_SIZE, combinational RAM read data for mem_address.
REQ-010 SHALL have port mem_address, output, ADDR_SIZE, RAM address, equal to pc at all times.
REQ-011 SHALL have port mem_load, output, 1, RAM write enable, constant 0.
REQ-012 SHALL have port instr, output, WORD_SIZE, registered fetched word.
REQ-013 SHALL have port instr_pc, output, ADDR_SIZE, address from which instr was fetched.
REQ-014 SHALL have port instr_valid, output, 1, instr holds an unconsumed word.
REQ-015 SHALL have port instr_ready, input, 1, downstream accepts instr this cycle.
REQ-016 SHALL have port pc, output, ADDR_SIZE, next fetch address.
REQ-017 SHALL have port running, output, 1, high in FETCH state.

Function
REQ-018 SHALL implement states IDLE and FETCH; running = (state == FETCH).
REQ-019 IDLE: start=1 and halt=0 -> FETCH next edge; otherwise remain; no capture occurs in IDLE.
REQ-020 FETCH: halt=1 -> IDLE next edge, pc unchanged, no capture that edge; halt has priority over start.
REQ-021 Transfer: a handshake completes on an edge where instr_valid=1 and instr_ready=1.
REQ-022 Capture condition in FETCH with halt=0, branch_taken=0: instr_valid=0 or instr_ready=1; on capture instr<=mem_value, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
REQ-023 With halt=0, branch_taken=0 and capture condition false, instr, instr_pc, instr_valid, pc SHALL hold.
REQ-024 Throughput: one word per cycle while instr_ready=1 continuously; latency from pc presentation to instr_valid is one edge.
REQ-025 pc increment SHALL wrap modulo 2^ADDR_SIZE (all-ones -> 0) without any flag or stall.
REQ-026 Branch (branch_taken=1, any state, halt=0): pc<=branch_target, instr_valid<=0 (unconsumed word discarded), no capture that edge; state unchanged.
REQ-027 branch_taken and halt together: pc<=branch_target, instr_valid<=0, state<=IDLE.
REQ-028 Outside branch, an unconsumed instr_valid word SHALL persist through halt and in IDLE until transferred; transfer in IDLE clears instr_valid.
REQ-029 instr and instr_pc SHALL not change while instr_valid=1 and instr_ready=0, except on branch.

Reset
REQ-030 reset=1 SHALL immediately force state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, independent of clk.
REQ-031 Reset asserted mid-fetch SHALL abandon any pending word; after release the unit waits for start.
REQ-032 mem_load SHALL be 0 during and after reset.

Verification (WORD_SIZE=8, ADDR_SIZE=4, RAM preloaded mem[i]=i+16)
REQ-033 Reset, start=1 one cycle, instr_ready=1 -> instr_valid after first edge in FETCH; instr=16,17,18 with instr_pc=0,1,2 on consecutive cycles.
REQ-034 Backpressure: instr_ready=0 for 3 cycles after first word -> instr=16, instr_pc=0 held, pc=1 held; ready=1 -> 17 next.
REQ-035 Wrap: branch_target=14, branch_taken pulse -> instr_valid=0 next edge, then instr_pc sequence 14,15,0,1 with instr=30,31,16,17.
REQ-036 Branch while instr_valid=1, instr_ready=0 -> word dropped, next valid word from branch_target.
REQ-037 halt=1 with pending word and instr_ready=0 -> IDLE, running=0, word held; ready=1 -> consumed, no further fetch until start.
REQ-038 reset pulsed asynchronously between edges during FETCH -> pc=0, instr_valid=0, running=0 before next edge.
